// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - HD44780 init/write sequencer with cursor tracking and automatic line wrap
module lcd_sequencer #(
    parameter int POWERUP_MS = 20,
    parameter int CLEAR_MS   = 2,
    parameter int COLS       = 16,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    input  logic       wr_finish,
    output logic       wr_enable,
    output logic       reg_sel,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       cursor_line,
    output logic [3:0] cursor_col,
    output logic       wr_timeout
);
    typedef enum logic [2:0] {S_PWR, S_ISSUE, S_BUSY, S_DELAY, S_IDLE} state_t;

    localparam int CNT_W    = 16;
    localparam int INIT_LEN = 4;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       init_idx;
    logic             load_init, load_wrap, load_req;
    logic             busy_done, is_clear, char_wraps, init_more;
    logic [4:0]       col_inc;
    logic [3:0]       col_set;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h0C;
            3'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    // Decoded from the held byte, which stays stable for the whole write.
    assign is_clear   = !reg_sel && (lcd_data[7:2] == 6'd0) && (lcd_data[1:0] != 2'd0);
    assign col_inc    = {1'b0, cursor_col} + 5'd1;
    assign char_wraps = reg_sel && (col_inc == 5'(COLS));
    assign col_set    = (lcd_data[3:0] > 4'(COLS - 1)) ? 4'(COLS - 1) : lcd_data[3:0];
    assign init_more  = !init_done && (init_idx < 3'(INIT_LEN));
    assign busy_done  = (state == S_BUSY) && (wr_finish || (cnt == CNT_W'(TIMEOUT_MS - 1)));
    assign wr_enable  = (state == S_ISSUE);
    assign req_ready  = (state == S_IDLE);

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            state <= S_PWR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_init  = 1'b0;
        load_wrap  = 1'b0;
        load_req   = 1'b0;
        case (state)
            S_PWR: begin
                if (cnt == CNT_W'(POWERUP_MS - 1)) begin
                    state_next = S_ISSUE;
                    load_init  = 1'b1;
                end
            end
            S_ISSUE: state_next = S_BUSY;
            S_BUSY: begin
                if (busy_done) begin
                    if (is_clear) begin
                        state_next = S_DELAY;
                    end else if (char_wraps) begin
                        state_next = S_ISSUE;
                        load_wrap  = 1'b1;
                    end else if (init_more) begin
                        state_next = S_ISSUE;
                        load_init  = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DELAY: begin
                if (cnt == CNT_W'(CLEAR_MS - 1)) begin
                    if (init_more) begin
                        state_next = S_ISSUE;
                        load_init  = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    state_next = S_ISSUE;
                    load_req   = 1'b1;
                end
            end
            default: state_next = S_PWR;
        endcase
    end

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            init_idx    <= '0;
            init_done   <= 1'b0;
            wr_timeout  <= 1'b0;
            reg_sel     <= 1'b0;
            lcd_data    <= 8'h00;
            cursor_line <= 1'b0;
            cursor_col  <= 4'd0;
        end else begin
            // One counter serves power-up, busy timeout and clear delay; it restarts on every state change.
            cnt <= (state_next != state) ? '0 : cnt + CNT_W'(1);
            if (state_next == S_IDLE) begin
                init_done <= 1'b1;
            end
            if ((state == S_BUSY) && !wr_finish && (cnt == CNT_W'(TIMEOUT_MS - 1))) begin
                wr_timeout <= 1'b1;
            end
            if (load_init) begin
                reg_sel  <= 1'b0;
                lcd_data <= init_byte(init_idx);
                init_idx <= init_idx + 3'd1;
            end else if (load_wrap) begin
                reg_sel  <= 1'b0;
                lcd_data <= cursor_line ? 8'h80 : 8'hC0;
            end else if (load_req) begin
                reg_sel  <= req_rs;
                lcd_data <= req_data;
            end
            if (busy_done) begin
                if (reg_sel) begin
                    if (char_wraps) begin
                        cursor_col  <= 4'd0;
                        cursor_line <= ~cursor_line;
                    end else begin
                        cursor_col <= col_inc[3:0];
                    end
                end else if (is_clear) begin
                    cursor_line <= 1'b0;
                    cursor_col  <= 4'd0;
                end else if (lcd_data[7]) begin
                    cursor_line <= lcd_data[6];
                    cursor_col  <= col_set;
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - randomized self-checking bench for lcd_sequencer against a cursor/write-list model
module tb_lcd_sequencer;
    localparam int POWERUP_MS = 20;
    localparam int CLEAR_MS   = 2;
    localparam int COLS       = 16;
    localparam int TIMEOUT_MS = 15;

    logic       clk_1ms = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       wr_finish = 1'b0;
    logic       req_ready, wr_enable, reg_sel, init_done, cursor_line, wr_timeout;
    logic [7:0] lcd_data;
    logic [3:0] cursor_col;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [8:0] seen_q[$];
    int         seen_cyc[$];
    int         fin_cnt = 0;
    bit         outstanding = 0;
    bit         stall = 0;
    int         m_line = 0;
    int         m_col = 0;
    bit         m_timeout = 0;
    logic [7:0] init_exp[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_sequencer #(
        .POWERUP_MS(POWERUP_MS),
        .CLEAR_MS  (CLEAR_MS),
        .COLS      (COLS),
        .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .clk_1ms    (clk_1ms),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rs     (req_rs),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wr_finish  (wr_finish),
        .wr_enable  (wr_enable),
        .reg_sel    (reg_sel),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .cursor_line(cursor_line),
        .cursor_col (cursor_col),
        .wr_timeout (wr_timeout)
    );

    always #5 clk_1ms = ~clk_1ms;
    always @(posedge clk_1ms) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Write-cycle block model: finish pulse sampled on the 5th edge after the start pulse.
    always @(negedge clk_1ms) begin
        if (reset) begin
            fin_cnt     = 0;
            outstanding = 0;
            wr_finish   = 1'b0;
        end else begin
            wr_finish = 1'b0;
            if (fin_cnt > 0) begin
                fin_cnt--;
                if (fin_cnt == 0) begin
                    outstanding = 0;
                    if (!stall) wr_finish = 1'b1;
                end
            end
            if (wr_enable) begin
                check_eq("single_wr_enable", outstanding, 0);
                outstanding = 1;
                fin_cnt     = 4;
                seen_q.push_back({reg_sel, lcd_data});
                seen_cyc.push_back(cyc);
            end
        end
    end

    task automatic check_reset_outputs();
        check_eq("rst_wr_enable", wr_enable, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_reg_sel", reg_sel, 0);
        check_eq("rst_lcd_data", lcd_data, 0);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_cursor_line", cursor_line, 0);
        check_eq("rst_cursor_col", cursor_col, 0);
        check_eq("rst_wr_timeout", wr_timeout, 0);
    endtask

    task automatic run_init();
        int rel;
        int n;
        bit ready_early;
        seen_q.delete();
        seen_cyc.delete();
        @(negedge clk_1ms);
        reset = 1'b0;
        rel = cyc;
        n = 0;
        ready_early = 0;
        while (!init_done && n < 300) begin
            @(negedge clk_1ms);
            if (!init_done && req_ready) ready_early = 1;
            n++;
        end
        check_eq("init_finished", (n < 300), 1);
        check_eq("ready_low_during_init", ready_early, 0);
        check_eq("init_write_count", seen_q.size(), 4);
        if (seen_q.size() == 4) begin
            check_eq("powerup_wait", seen_cyc[0] - rel, POWERUP_MS);
            for (int i = 0; i < 4; i++) check_eq("init_byte", seen_q[i], {1'b0, init_exp[i]});
            check_eq("init_gap_plain", seen_cyc[1] - seen_cyc[0], 5);
            check_eq("init_gap_clear", seen_cyc[3] - seen_cyc[2], 5 + CLEAR_MS);
        end
        check_eq("init_ready", req_ready, 1);
        check_eq("init_cursor_line", cursor_line, 0);
        check_eq("init_cursor_col", cursor_col, 0);
        seen_q.delete();
        seen_cyc.delete();
        m_line = 0;
        m_col = 0;
        m_timeout = 0;
    endtask

    task automatic send_and_check(input logic rs, input logic [7:0] data);
        int         n;
        int         low;
        int         cost;
        int         exp_low;
        logic [8:0] exp_q[$];
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk_1ms);
            n++;
        end
        check_eq("ready_before_send", req_ready, 1);
        seen_q.delete();
        seen_cyc.delete();
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = data;
        @(negedge clk_1ms);
        req_valid = 1'b0;
        low = 0;
        while (!req_ready && low < 200) begin
            low++;
            @(negedge clk_1ms);
        end
        cost = stall ? 1 + TIMEOUT_MS : 5;
        if (stall) m_timeout = 1;
        exp_q.push_back({rs, data});
        exp_low = cost;
        if (rs) begin
            m_col++;
            if (m_col == COLS) begin
                m_col  = 0;
                m_line = 1 - m_line;
                exp_q.push_back({1'b0, (m_line == 1) ? 8'hC0 : 8'h80});
                exp_low += cost;
            end
        end else if (data == 8'h01 || data == 8'h02 || data == 8'h03) begin
            m_line = 0;
            m_col  = 0;
            exp_low += CLEAR_MS;
        end else if (data[7]) begin
            m_line = int'(data[6]);
            m_col  = (int'(data[3:0]) > COLS - 1) ? COLS - 1 : int'(data[3:0]);
        end
        check_eq("ready_low_cycles", low, exp_low);
        check_eq("write_count", seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            check_eq("write_byte", seen_q[i], exp_q[i]);
        end
        check_eq("cursor_line", cursor_line, m_line);
        check_eq("cursor_col", cursor_col, m_col);
        check_eq("wr_timeout", wr_timeout, m_timeout);
        check_eq("init_done_held", init_done, 1);
    endtask

    task automatic random_traffic(input int count);
        int         r;
        logic [7:0] d;
        for (int k = 0; k < count; k++) begin
            r = $urandom_range(0, 99);
            if (r < 65) begin
                d = 8'($urandom_range(32, 126));
                send_and_check(1'b1, d);
            end else if (r < 75) begin
                d = 8'h80 | 8'($urandom_range(0, 127));
                send_and_check(1'b0, d);
            end else if (r < 82) begin
                d = 8'($urandom_range(1, 3));
                send_and_check(1'b0, d);
            end else begin
                d = 8'($urandom_range(4, 127));
                send_and_check(1'b0, d);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk_1ms);
        check_reset_outputs();
        run_init();

        send_and_check(1'b1, 8'h41);
        send_and_check(1'b0, 8'h01);
        for (int i = 0; i < 32; i++) send_and_check(1'b1, 8'h41 + 8'($urandom_range(0, 25)));
        send_and_check(1'b0, 8'hC5);
        send_and_check(1'b0, 8'h8F);
        send_and_check(1'b0, 8'h01);
        send_and_check(1'b0, 8'h03);
        random_traffic(60);

        stall = 1;
        send_and_check(1'b1, 8'h5A);
        stall = 0;
        send_and_check(1'b1, 8'h5B);

        // Reset while a write is in flight.
        while (!req_ready) @(negedge clk_1ms);
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h42;
        @(negedge clk_1ms);
        req_valid = 1'b0;
        @(negedge clk_1ms);
        @(negedge clk_1ms);
        #1 reset = 1'b1;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk_1ms);
        run_init();
        random_traffic(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        failures++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
